// File: rtl/mac_pkg.sv
// Shared definitions for the shift_mac_l1 read side: FSM states, default MAC
// width and the rounded-shift/saturate helper used by every descaling layer.
package mac_pkg;

    localparam int MAC_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Rounded arithmetic right shift (ties toward +inf) followed by a clamp to
    // a signed out_w range. The 32-bit working width keeps the rounding add
    // from wrapping for any MAC width up to 31 bits.
    function automatic logic signed [31:0] descale_sat(input logic signed [31:0] value,
                                                       input int                 shift,
                                                       input int                 out_w);
        logic signed [31:0] t;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        t = value;
        if (shift > 0) begin
            t = value + (32'sd1 <<< (shift - 1));
        end
        t  = t >>> shift;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        if (t > hi) begin
            t = hi;
        end else if (t < lo) begin
            t = lo;
        end
        return t;
    endfunction

endpackage

// File: rtl/mac_result_reader_if.sv
// Stream bundle between the MAC, the result reader and its downstream consumer.
interface mac_result_reader_if #(
    parameter int IN_W  = mac_pkg::MAC_W,
    parameter int OUT_W = 8
);
    // mac_valid has no backpressure: a sample is taken whenever it is high.
    // out side: a word moves only on a cycle where out_valid && out_ready;
    // out_data is stable while out_valid is high and not yet accepted.
    logic signed [IN_W-1:0]  mac_data;
    logic                    mac_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  mac_data,
        input  mac_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );

    modport master (
        output mac_data,
        output mac_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead FIFO with a registered head word; empty reflects the head register.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             head_valid;
    logic             do_pop;
    logic             do_push;
    logic [AW:0]      remain;
    logic [AW-1:0]    rd_next;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = !head_valid;
    assign level   = count;
    assign do_pop  = pop && head_valid;
    assign do_push = push && (!full || do_pop);
    assign remain  = count - (AW + 1)'(do_pop);
    assign rd_next = rd_ptr + AW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // The head register is refreshed from words already in memory, so a word
    // pushed into an empty FIFO shows up one cycle after it is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            rdata      <= '0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_next;
            count      <= remain + (AW + 1)'(do_push);
            head_valid <= (remain != '0);
            if (remain != '0) begin
                rdata <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/mac_result_reader.sv
// Captures the MAC result stream after warm-up, descales/saturates each sample
// and queues it for a valid/ready consumer.
module mac_result_reader
    import mac_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 2,
    parameter int WARMUP = 3,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   clr,
    mac_result_reader_if.slave     bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   busy,
    output state_t                 dbg_state
);

    localparam int CW = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

    state_t                  state_q;
    state_t                  state_d;
    logic [CW-1:0]           warm_q;
    logic [CW-1:0]           warm_d;
    logic                    capture;
    logic                    ds_valid;
    logic signed [OUT_W-1:0] ds_data;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    fifo_pop;
    logic [OUT_W-1:0]        fifo_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        if (clr) begin
            state_d = IDLE;
            warm_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        warm_d  = '0;
                        state_d = (WARMUP == 0) ? RUN : WARM;
                    end
                end
                WARM: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (bus.mac_valid) begin
                        warm_d = warm_q + CW'(1);
                        if (int'(warm_q) == WARMUP - 1) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A sample arriving with stop is still taken because capture looks at the
    // current state, not the next one.
    assign capture = (state_q == RUN) && bus.mac_valid && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_valid <= 1'b0;
            ds_data  <= '0;
        end else begin
            ds_valid <= capture;
            if (capture) begin
                ds_data <= OUT_W'(descale_sat(32'(signed'(bus.mac_data)), SHIFT, OUT_W));
            end
        end
    end

    assign fifo_pop = !fifo_empty && bus.out_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (ds_valid),
        .wdata (ds_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clr) begin
            overflow <= 1'b0;
        end else if (ds_valid && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    assign bus.out_data  = signed'(fifo_rdata);
    assign bus.out_valid = !fifo_empty;
    assign busy          = (state_q != IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mac_result_reader.sv
// Directed bench for mac_result_reader: queue-based scoreboard on the output
// stream plus point checks of level/overflow/busy/state.
module tb_mac_result_reader;
  import mac_pkg::*;

  localparam int IN_W   = 16;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 2;
  localparam int WARMUP = 3;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic clr = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic overflow;
  logic busy;
  state_t dbg_state;

  mac_result_reader_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  mac_result_reader #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT),
    .WARMUP (WARMUP),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .clr       (clr),
    .bus       (bus),
    .level     (level),
    .overflow  (overflow),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic signed [OUT_W-1:0] exp_s;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // scoreboard monitor: every accepted output word is compared with the queue head
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0d with nothing expected", bus.out_data);
      end else begin
        exp_s = signed'(exp_q.pop_front());
        check("out_data", bus.out_data, exp_s);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic send(input logic signed [IN_W-1:0] v, input bit cap, input logic signed [OUT_W-1:0] ev);
    bus.mac_data = v;
    bus.mac_valid = 1'b1;
    if (cap) exp_q.push_back(ev);
    tick();
    bus.mac_valid = 1'b0;
  endtask

  task automatic warm();
    for (int i = 0; i < WARMUP; i++) send(16'sd7, 1'b0, 8'sd0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_queue_left", exp_q.size(), 0);
    check("drain_level", level, 0);
  endtask

  initial begin
    bus.mac_data = '0;
    bus.mac_valid = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic path with latency check, then warm-up and saturation vectors
    pulse_start();
    check("busy_after_start", busy, 1);
    check("state_warm", dbg_state, WARM);
    warm();
    check("state_run", dbg_state, RUN);
    bus.out_ready = 1'b1;
    send(16'sd100, 1'b1, 8'sd25);
    check("lat_n0_valid", bus.out_valid, 0);
    tick();
    check("lat_n1_valid", bus.out_valid, 0);
    check("lat_n1_level", level, 1);
    tick();
    check("lat_n2_valid", bus.out_valid, 1);
    check("lat_n2_data", bus.out_data, 25);
    send(16'sd10, 1'b1, 8'sd3);
    send(-16'sd6, 1'b1, -8'sd1);
    send(16'sd21, 1'b1, 8'sd5);
    send(16'h7FFF, 1'b1, 8'sd127);
    send(16'h8000, 1'b1, -8'sd128);
    send(16'h01FE, 1'b1, 8'sd127);
    send(16'hFE00, 1'b1, -8'sd128);
    send(16'h01FC, 1'b1, 8'sd127);
    drain(50);

    pulse_stop();
    check("busy_after_stop", busy, 0);
    pulse_start();
    send(16'sd7, 1'b0, 8'sd0);
    send(16'sd7, 1'b0, 8'sd0);
    send(16'sd7, 1'b0, 8'sd0);
    send(16'sd40, 1'b1, 8'sd10);
    drain(50);

    // overflow: 10 samples into a stalled FIFO, first 8 survive
    pulse_stop();
    pulse_start();
    warm();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) send(16'(4 * i), i <= DEPTH, 8'(i));
    tick();
    tick();
    check("ovf_level", level, DEPTH);
    check("ovf_flag", overflow, 1);
    check("ovf_head", bus.out_data, 1);
    drain(60);
    check("ovf_sticky", overflow, 1);
    pulse_clr();
    check("clr_overflow", overflow, 0);
    check("clr_busy", busy, 0);

    // full FIFO with a pop on the write cycle: sample accepted
    pulse_start();
    warm();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) send(16'(4 * i), 1'b1, 8'(i));
    tick();
    tick();
    check("full_level", level, DEPTH);
    bus.mac_data = 16'sd36;
    bus.mac_valid = 1'b1;
    exp_q.push_back(8'd9);
    tick();
    bus.mac_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("pushpop_level", level, DEPTH);
    check("pushpop_no_ovf", overflow, 0);
    drain(60);
    check("pushpop_no_ovf_end", overflow, 0);

    // clr together with stop while overflowed in RUN
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send(16'sd80, 1'b0, 8'sd0);
    tick();
    check("pre_clr_overflow", overflow, 1);
    clr = 1'b1;
    stop = 1'b1;
    tick();
    clr = 1'b0;
    stop = 1'b0;
    check("clrstop_state", dbg_state, IDLE);
    check("clrstop_level", level, 0);
    check("clrstop_overflow", overflow, 0);
    check("clrstop_valid", bus.out_valid, 0);

    // start while RUN is ignored; stop keeps its own sample, drops later ones
    pulse_start();
    warm();
    bus.out_ready = 1'b1;
    send(16'sd44, 1'b1, 8'sd11);
    pulse_start();
    check("restart_ignored", dbg_state, RUN);
    send(16'sd48, 1'b1, 8'sd12);
    send(16'sd52, 1'b1, 8'sd13);
    bus.mac_data = 16'sd56;
    bus.mac_valid = 1'b1;
    stop = 1'b1;
    exp_q.push_back(8'd14);
    tick();
    stop = 1'b0;
    bus.mac_data = 16'sd60;
    tick();
    bus.mac_data = 16'sd64;
    tick();
    bus.mac_valid = 1'b0;
    check("stop_busy", busy, 0);
    drain(50);

    // asynchronous reset in the middle of a drain
    pulse_start();
    warm();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'(4 * i), 1'b1, 8'(i));
    tick();
    tick();
    bus.out_ready = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_data", bus.out_data, 0);
    check("arst_level", level, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_valid", bus.out_valid, 0);
    check("post_rst_state", dbg_state, IDLE);
    pulse_start();
    warm();
    send(-16'sd100, 1'b1, -8'sd25);
    drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
